dmem_bytelane: RTL and testbench

Parametrised, byte-addressable, little-endian data memory for the MIPS datapath, sitting behind the load/store unit in the MEM stage. It is the successor to the current fixed 128-byte, word-only data memory. It adds configurable depth, byte/half/word stores and loads, load sign/zero extension, a registered read with a valid strobe, and a post-reset clear sequencer. It also adds optional misaligned-access trapping.

---
 rtl/dmem_bytelane_if.sv | 31 +++
 rtl/dmem_bytelane.sv | 152 +++++++++++++++
 tb/tb_dmem_bytelane.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: load/store bus between the MEM-stage load/store unit and
// the byte-lane data memory. The master drives requests; the slave returns
// load data, the valid strobe, the clear-busy flag and the misalignment pulse.
interface dmem_bytelane_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] rd_add;
    logic              memRead;
    logic [1:0]        rd_size;
    logic              rd_signed;
    logic [ADDR_W-1:0] wr_add;
    logic [31:0]       wr_data;
    logic              memWrite;
    logic [1:0]        wr_size;
    logic [31:0]       data;
    logic              data_valid;
    logic              init_busy;
    logic              misalign_err;

    modport master (
        output rd_add, memRead, rd_size, rd_signed,
        output wr_add, wr_data, memWrite, wr_size,
        input  data, data_valid, init_busy, misalign_err
    );

    modport slave (
        input  rd_add, memRead, rd_size, rd_signed,
        input  wr_add, wr_data, memWrite, wr_size,
        output data, data_valid, init_busy, misalign_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressable little-endian data memory with byte/half/word
// access, sign/zero-extended registered loads and a post-reset clear sequencer.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are suppressed and flagged on misalign_err; otherwise they
// proceed at the literal byte address (wrapping) and misalign_err stays 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_INIT | clearing one word per cycle at bytes 4k..4k+3; requests ignored
// S_RUN  | normal load/store operation
module dmem_bytelane #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 128,
    parameter int INIT_CLEAR = 1
) (
    input logic            clk,
    input logic            rst_n,
    dmem_bytelane_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(DEPTH / 4);
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH / 4 - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic            init_busy_c;
    logic            init_we;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   ra, wa;
    logic            rd_mis, wr_mis;
    logic            run, load_go, store_go;
    logic [7:0]      rb [4];
    logic [31:0]     rd_ext;
    logic [3:0]      we;
    logic [AW-1:0]   wad [4];
    logic [7:0]      wby [4];
    logic            unused_addr_hi;

    // Only the low address bits select a byte; the rest wrap away.
    assign ra = bus.rd_add[AW-1:0];
    assign wa = bus.wr_add[AW-1:0];
    assign unused_addr_hi = ^{bus.rd_add[ADDR_W-1:AW], bus.wr_add[ADDR_W-1:AW]};

`ifdef DMEM_MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word needs addr[1:0]=00; bytes never trap.
    always_comb begin
        rd_mis = 1'b0;
        wr_mis = 1'b0;
        case (bus.rd_size)
            2'b00:   rd_mis = 1'b0;
            2'b01:   rd_mis = ra[0];
            default: rd_mis = |ra[1:0];
        endcase
        case (bus.wr_size)
            2'b00:   wr_mis = 1'b0;
            2'b01:   wr_mis = wa[0];
            default: wr_mis = |wa[1:0];
        endcase
    end
`else
    assign rd_mis = 1'b0;
    assign wr_mis = 1'b0;
`endif

    assign run      = (state == S_RUN);
    assign load_go  = run & bus.memRead  & ~rd_mis;
    assign store_go = run & bus.memWrite & ~wr_mis;

    // State register and clear-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            k     <= '0;
        end else begin
            state <= state_nxt;
            if (init_we) k <= k + KW'(1);
        end
    end

    // Next state: leave INIT once the last word has been cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (k == K_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        init_busy_c = (state == S_INIT);
        init_we     = (state == S_INIT);
    end

    assign bus.init_busy = init_busy_c;

    // Gather the four candidate read bytes (wrapping) and size/extend them.
    always_comb begin
        for (int i = 0; i < 4; i++) rb[i] = mem[ra + AW'(i)];
        case (bus.rd_size)
            2'b00:   rd_ext = {{24{bus.rd_signed & rb[0][7]}}, rb[0]};
            2'b01:   rd_ext = {{16{bus.rd_signed & rb[1][7]}}, rb[1], rb[0]};
            default: rd_ext = {rb[3], rb[2], rb[1], rb[0]};
        endcase
    end

    // Per-lane write port: clear words during INIT, sized stores in RUN.
    always_comb begin
        we = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wad[i] = wa + AW'(i);
            wby[i] = bus.wr_data[8*i +: 8];
        end
        if (init_we) begin
            we = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                wad[i] = {k, 2'b00} + AW'(i);
                wby[i] = 8'h00;
            end
        end else if (store_go) begin
            case (bus.wr_size)
                2'b00:   we = 4'b0001;
                2'b01:   we = 4'b0011;
                default: we = 4'b1111;
            endcase
        end
    end

    // Byte array; the read path sees pre-store contents within the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[wad[i]] <= wby[i];
        end
    end

    // Registered load result, valid strobe and misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data         <= '0;
            bus.data_valid   <= 1'b0;
            bus.misalign_err <= 1'b0;
        end else begin
            bus.data_valid   <= load_go;
            if (load_go) bus.data <= rd_ext;
            bus.misalign_err <= run & ((bus.memRead & rd_mis) | (bus.memWrite & wr_mis));
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: directed and randomized checks of dmem_bytelane against a
// byte-array reference model (DEPTH=128, INIT_CLEAR=1).
module tb_dmem_bytelane;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_bytelane_if #(.ADDR_W(32)) bus ();

    dmem_bytelane #(.ADDR_W(32), .DEPTH(DEPTH), .INIT_CLEAR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          passed = 0;
    logic [7:0]  mdl [DEPTH];
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_err;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (nbytes(sz) == 2 && (a % 2) != 0) || (nbytes(sz) == 4 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
        int n = nbytes(sz);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(mdl[(a + 32'(i)) % DEPTH]) << (8 * i));
        if (sgn && n == 1 && v >= 128)   v = v - 32'd256;
        if (sgn && n == 2 && v >= 32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) mdl[(a + 32'(i)) % DEPTH] = 8'(d >> (8 * i));
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        exp_data = 32'h0;
    endtask

    // Present one cycle of requests, compute the expected outcome, advance one edge.
    task automatic op(input bit re, input logic [31:0] ra, input logic [1:0] rs, input bit sg,
                      input bit wre, input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] ws);
        bit ld_ok, st_ok;
`ifdef DMEM_MISALIGN_TRAP_EN
        ld_ok   = re && !misaligned(ra, rs);
        st_ok   = wre && !misaligned(wa, ws);
        exp_err = (re && misaligned(ra, rs)) || (wre && misaligned(wa, ws));
`else
        ld_ok   = re;
        st_ok   = wre;
        exp_err = 1'b0;
`endif
        exp_valid = ld_ok;
        if (ld_ok) exp_data = model_load(ra, rs, sg);
        if (st_ok) model_store(wa, ws, wd);
        bus.rd_add = ra; bus.rd_size = rs; bus.rd_signed = sg; bus.memRead = re;
        bus.wr_add = wa; bus.wr_data = wd; bus.wr_size = ws; bus.memWrite = wre;
        @(posedge clk); #1;
        bus.memRead = 1'b0; bus.memWrite = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit sg);
        op(1'b1, a, sz, sg, 1'b0, 32'h0, 32'h0, 2'b10);
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        op(1'b0, 32'h0, 2'b10, 1'b0, 1'b1, a, d, sz);
    endtask

    // Count init_busy-high edges after release; requests are driven throughout.
    task automatic run_init(output int cnt, output int bad);
        cnt = 0; bad = 0;
        bus.memRead = 1'b1; bus.rd_add = 32'h0; bus.rd_size = 2'b10;
        bus.memWrite = 1'b1; bus.wr_add = 32'h0; bus.wr_data = 32'hDEADBEEF; bus.wr_size = 2'b10;
        while (bus.init_busy === 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.data_valid !== 1'b0 || bus.misalign_err !== 1'b0) bad++;
        end
        bus.memRead = 1'b0; bus.memWrite = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int cnt, bad;
        bus.rd_add = 0; bus.memRead = 0; bus.rd_size = 0; bus.rd_signed = 0;
        bus.wr_add = 0; bus.wr_data = 0; bus.memWrite = 0; bus.wr_size = 0;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.data !== 32'h0) $display("FAIL reset_data: got %h expected 0", bus.data); else passed++;
        checks++; if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.data_valid); else passed++;
        checks++; if (bus.misalign_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.misalign_err); else passed++;
        checks++; if (bus.init_busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", bus.init_busy); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_init(cnt, bad);
        checks++; if (cnt !== 32) $display("FAIL init_length: got %0d expected 32", cnt); else passed++;
        checks++; if (bad !== 0) $display("FAIL init_ignores_req: got %0d strobes expected 0", bad); else passed++;
        ld(32'h7C, 2'b10, 1'b0);
        checks++; if (bus.data_valid !== 1'b1 || bus.data !== 32'h0)
            $display("FAIL load_7c: got v=%b d=%h expected v=1 d=00000000", bus.data_valid, bus.data); else passed++;
        op(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.data_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b expected 0", bus.data_valid); else passed++;
        ld(32'h0, 2'b10, 1'b0);
        checks++; if (bus.data !== 32'h0) $display("FAIL init_store_dropped: got %h expected 00000000", bus.data); else passed++;
    endtask

    task automatic test_directed();
        logic [31:0] want [4];
        want[0] = 32'hDD; want[1] = 32'hCC; want[2] = 32'hBB; want[3] = 32'hAA;
        st(32'h10, 2'b10, 32'hAABBCCDD);
        for (int i = 0; i < 4; i++) begin
            ld(32'h10 + 32'(i), 2'b00, 1'b0);
            checks++; if (bus.data_valid !== 1'b1 || bus.data !== want[i])
                $display("FAIL byte_load_%0d: got v=%b d=%h expected v=1 d=%h", i, bus.data_valid, bus.data, want[i]); else passed++;
        end
        ld(32'h12, 2'b01, 1'b1);
        checks++; if (bus.data !== 32'hFFFFAABB) $display("FAIL half_signed: got %h expected FFFFAABB", bus.data); else passed++;
        ld(32'h12, 2'b01, 1'b0);
        checks++; if (bus.data !== 32'h0000AABB) $display("FAIL half_unsigned: got %h expected 0000AABB", bus.data); else passed++;
        st(32'h20, 2'b10, 32'h11223344);
        st(32'h21, 2'b00, 32'hFFFFFF80);
        ld(32'h20, 2'b10, 1'b1);
        checks++; if (bus.data !== 32'h11228044) $display("FAIL byte_merge: got %h expected 11228044", bus.data); else passed++;
        ld(32'h21, 2'b00, 1'b1);
        checks++; if (bus.data !== 32'hFFFFFF80) $display("FAIL byte_signed: got %h expected FFFFFF80", bus.data); else passed++;
        st(32'h22, 2'b01, 32'h0000BEEF);
        ld(32'h20, 2'b11, 1'b1);
        checks++; if (bus.data !== 32'hBEEF8044) $display("FAIL half_store_size3_load: got %h expected BEEF8044", bus.data); else passed++;
    endtask

    task automatic test_rbw();
        op(1'b1, 32'h40, 2'b10, 1'b0, 1'b1, 32'h40, 32'h12345678, 2'b10);
        checks++; if (bus.data_valid !== 1'b1 || bus.data !== 32'h0)
            $display("FAIL rbw_old: got v=%b d=%h expected v=1 d=00000000", bus.data_valid, bus.data); else passed++;
        ld(32'h40, 2'b10, 1'b0);
        checks++; if (bus.data !== 32'h12345678) $display("FAIL rbw_new: got %h expected 12345678", bus.data); else passed++;
    endtask

    task automatic test_misalign();
        logic [31:0] held;
        st(32'h0, 2'b10, 32'h44332211);
        st(32'h4, 2'b10, 32'h88776655);
        ld(32'h4, 2'b10, 1'b0);
        held = 32'h88776655;
        ld(32'h83, 2'b10, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (bus.misalign_err !== 1'b1 || bus.data_valid !== 1'b0 || bus.data !== held)
            $display("FAIL mis_load: got e=%b v=%b d=%h expected e=1 v=0 d=%h", bus.misalign_err, bus.data_valid, bus.data, held); else passed++;
`else
        checks++; if (bus.misalign_err !== 1'b0 || bus.data_valid !== 1'b1 || bus.data !== 32'h77665544)
            $display("FAIL mis_load: got e=%b v=%b d=%h expected e=0 v=1 d=77665544", bus.misalign_err, bus.data_valid, bus.data); else passed++;
`endif
        st(32'h5, 2'b01, 32'h0000BEEF);
        checks++; if (bus.misalign_err !== exp_err) $display("FAIL mis_store_err: got %b expected %b", bus.misalign_err, exp_err); else passed++;
        ld(32'h4, 2'b10, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (bus.data !== 32'h88776655) $display("FAIL mis_store_data: got %h expected 88776655", bus.data); else passed++;
`else
        checks++; if (bus.data !== 32'h88BEEF55) $display("FAIL mis_store_data: got %h expected 88BEEF55", bus.data); else passed++;
`endif
        op(1'b1, 32'h1, 2'b01, 1'b0, 1'b1, 32'h2, 32'h0, 2'b10);
        checks++; if (bus.misalign_err !== exp_err) $display("FAIL mis_both: got %b expected %b", bus.misalign_err, exp_err); else passed++;
        op(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.misalign_err !== 1'b0) $display("FAIL mis_single_pulse: got %b expected 0", bus.misalign_err); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) st(32'h60 + 32'(4 * i), 2'b10, 32'hC0DE0000 + 32'(i));
        for (int i = 0; i < 8; i++) begin
            ld(32'h60 + 32'(4 * i), 2'b10, 1'b0);
            checks++; if (bus.data_valid !== 1'b1 || bus.data !== 32'hC0DE0000 + 32'(i))
                $display("FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", i, bus.data_valid, bus.data, 32'hC0DE0000 + 32'(i)); else passed++;
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 400; n++) begin
            bit re, wre, sg;
            logic [31:0] ra, wa, wd;
            logic [1:0] rs, ws;
            re = 1'($urandom_range(0, 1)); wre = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            ra = $urandom(); wa = $urandom(); wd = $urandom();
            rs = 2'($urandom_range(0, 3)); ws = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) ra = ra & ~32'h3;
            if ($urandom_range(0, 3) != 0) wa = wa & ~32'h3;
            if ($urandom_range(0, 1) != 0) begin ra = ra & 32'hFF; wa = (ra & ~32'h3) + 32'($urandom_range(0, 1) * 4); end
            op(re, ra, rs, sg, wre, wa, wd, ws);
            checks++;
            if (bus.data_valid !== exp_valid || bus.data !== exp_data || bus.misalign_err !== exp_err) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b", n,
                             bus.data_valid, bus.data, bus.misalign_err, exp_valid, exp_data, exp_err);
            end else passed++;
        end
    endtask

    task automatic test_reset_mid_init();
        int cnt, bad;
        st(32'h10, 2'b10, 32'h5A5AA5A5);
        ld(32'h10, 2'b10, 1'b0);
        checks++; if (bus.data !== 32'h5A5AA5A5) $display("FAIL pre_reset_load: got %h expected 5A5AA5A5", bus.data); else passed++;
        bus.memRead = 1'b1; bus.rd_add = 32'h10; bus.rd_size = 2'b10;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.data !== 32'h0 || bus.data_valid !== 1'b0 || bus.init_busy !== 1'b1 || bus.misalign_err !== 1'b0)
            $display("FAIL async_reset: got d=%h v=%b b=%b e=%b expected d=0 v=0 b=1 e=0",
                     bus.data, bus.data_valid, bus.init_busy, bus.misalign_err); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.data_valid !== 1'b0) $display("FAIL inflight_dropped: got %b expected 0", bus.data_valid); else passed++;
        bus.memRead = 1'b0;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (bus.init_busy !== 1'b1) $display("FAIL mid_init_busy: got %b expected 1", bus.init_busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.init_busy !== 1'b1 || bus.data_valid !== 1'b0 || bus.data !== 32'h0)
            $display("FAIL mid_init_reset: got b=%b v=%b d=%h expected b=1 v=0 d=0", bus.init_busy, bus.data_valid, bus.data); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_init(cnt, bad);
        checks++; if (cnt !== 32) $display("FAIL reinit_length: got %0d expected 32", cnt); else passed++;
        checks++; if (bad !== 0) $display("FAIL reinit_ignores_req: got %0d strobes expected 0", bad); else passed++;
        ld(32'h10, 2'b10, 1'b0);
        checks++; if (bus.data_valid !== 1'b1 || bus.data !== 32'h0)
            $display("FAIL cleared_after_reinit: got v=%b d=%h expected v=1 d=00000000", bus.data_valid, bus.data); else passed++;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_directed();
        test_rbw();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
